// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multi-cycle MIPS-lite controller: FSM states,
// opcode/funct values, datapath select encodings and decoded-instruction flags.
package mc_controller_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [4:0] RA_IDX = 5'd31;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SLT = 2'b11;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;
  localparam logic [1:0] PC_JR  = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  typedef struct packed {
    logic addu;
    logic subu;
    logic slt;
    logic jr;
    logic ori;
    logic lw;
    logic sw;
    logic beq;
    logic lui;
    logic j;
    logic jal;
    logic addi;
    logic addiu;
    logic unknown;
  } instr_t;

endpackage

// File: rtl/mc_controller_instr_decode.sv
// Combinational instruction decoder: opcode/funct to one-hot instruction flags,
// with "unknown" raised for anything outside the supported subset.
module instr_decode
  import mc_controller_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  output instr_t     o_instr
);

  always_comb begin
    o_instr = '0;
    case (i_opcode)
      OP_RTYPE: begin
        case (i_funct)
          FN_ADDU: o_instr.addu    = 1'b1;
          FN_SUBU: o_instr.subu    = 1'b1;
          FN_SLT:  o_instr.slt     = 1'b1;
          FN_JR:   o_instr.jr      = 1'b1;
          default: o_instr.unknown = 1'b1;
        endcase
      end
      OP_ORI:   o_instr.ori     = 1'b1;
      OP_LW:    o_instr.lw      = 1'b1;
      OP_SW:    o_instr.sw      = 1'b1;
      OP_BEQ:   o_instr.beq     = 1'b1;
      OP_LUI:   o_instr.lui     = 1'b1;
      OP_J:     o_instr.j       = 1'b1;
      OP_JAL:   o_instr.jal     = 1'b1;
      OP_ADDI:  o_instr.addi    = 1'b1;
      OP_ADDIU: o_instr.addiu   = 1'b1;
      default:  o_instr.unknown = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multi-cycle control FSM for the MIPS-lite datapath: sequences IF/ID/EXE/MEM/WB,
// stalls on mem_ready and pulses retire once per completed instruction.
module mc_controller
  import mc_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opeCode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic [1:0] WDsel,
  output logic       ALUsrc,
  output logic [1:0] ALUop,
  output logic       ALUsign,
  output logic [1:0] ExtOp,
  output logic [1:0] PCsrc,
  output logic       retire,
  output logic [2:0] state
);

  instr_t     w_dec;
  state_t     r_state;
  state_t     w_next;
  logic       w_pcw;
  logic       w_irw;
  logic       w_mreq;
  logic       w_memw;
  logic       w_regw;
  logic       w_retire;
  logic [1:0] w_aluop;
  logic       w_alusrc;
  logic       w_alusign;
  logic [1:0] w_extop;

  instr_decode u_decode (
    .i_opcode (opeCode),
    .i_funct  (funct),
    .o_instr  (w_dec)
  );

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IF;
    else       r_state <= w_next;
  end

  // ALU setup per instruction, same encodings as the single-cycle decoder
  always_comb begin
    w_aluop   = ALU_ADD;
    w_alusrc  = 1'b0;
    w_alusign = 1'b0;
    w_extop   = EXT_ZERO;
    if (w_dec.subu || w_dec.beq) w_aluop = ALU_SUB;
    if (w_dec.ori)               w_aluop = ALU_OR;
    if (w_dec.slt) begin
      w_aluop   = ALU_SLT;
      w_alusign = 1'b1;
    end
    if (w_dec.addi) w_alusign = 1'b1;
    if (w_dec.ori || w_dec.lui || w_dec.addi || w_dec.addiu || w_dec.lw || w_dec.sw)
      w_alusrc = 1'b1;
    if (w_dec.addi || w_dec.addiu || w_dec.lw || w_dec.sw || w_dec.beq)
      w_extop = EXT_SIGN;
    if (w_dec.lui) w_extop = EXT_LUI;
  end

  always_comb begin
    w_next   = r_state;
    w_pcw    = 1'b0;
    w_irw    = 1'b0;
    w_mreq   = 1'b0;
    w_memw   = 1'b0;
    w_regw   = 1'b0;
    w_retire = 1'b0;
    RegDst   = RD_RT;
    WDsel    = WD_ALU;
    PCsrc    = PC_SEQ;
    ALUop    = ALU_ADD;
    ALUsrc   = 1'b0;
    ALUsign  = 1'b0;
    ExtOp    = EXT_ZERO;

    // ALU controls stay stable from EXE through WB so the result is held
    if (r_state == S_EXE || r_state == S_MEM || r_state == S_WB) begin
      ALUop   = w_aluop;
      ALUsrc  = w_alusrc;
      ALUsign = w_alusign;
      ExtOp   = w_extop;
    end

    case (r_state)
      S_IF: begin
        w_mreq = 1'b1;
        if (mem_ready) begin
          w_irw  = 1'b1;
          w_pcw  = 1'b1;
          w_next = S_ID;
        end
      end
      S_ID: begin
        if (w_dec.j || w_dec.jal) begin
          w_pcw = 1'b1;
          PCsrc = PC_JMP;
        end
        if (w_dec.jal) begin
          w_regw = 1'b1;
          RegDst = RD_RA;
          WDsel  = WD_PC4;
        end
        if (w_dec.jr) begin
          w_pcw = 1'b1;
          PCsrc = PC_JR;
        end
        if (w_dec.j || w_dec.jal || w_dec.jr || w_dec.unknown) begin
          w_retire = 1'b1;
          w_next   = S_IF;
        end else begin
          w_next = S_EXE;
        end
      end
      S_EXE: begin
        if (w_dec.beq) begin
          w_pcw    = zero;
          PCsrc    = PC_BR;
          w_retire = 1'b1;
          w_next   = S_IF;
        end else if (w_dec.lw || w_dec.sw) begin
          w_next = S_MEM;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_mreq = 1'b1;
        if (mem_ready) begin
          if (w_dec.sw) begin
            w_memw   = 1'b1;
            w_retire = 1'b1;
            w_next   = S_IF;
          end else if (w_dec.lw) begin
            w_next = S_WB;
          end else begin
            w_next = S_IF;
          end
        end
      end
      S_WB: begin
        w_retire = 1'b1;
        w_regw   = ~(w_dec.addi && overflow);
        if (w_dec.lw) WDsel = WD_MEM;
        if (w_dec.addu || w_dec.subu || w_dec.slt) RegDst = RD_RD;
        w_next = S_IF;
      end
      default: w_next = S_IF;
    endcase
  end

  // Reset suppresses every enable immediately, even mid-instruction
  assign PCWrite  = w_pcw    & ~reset;
  assign IRWrite  = w_irw    & ~reset;
  assign mem_req  = w_mreq   & ~reset;
  assign MemWrite = w_memw   & ~reset;
  assign RegWrite = w_regw   & ~reset;
  assign retire   = w_retire & ~reset;
  assign state    = r_state;

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed scenarios plus random
// instruction streams compared against a per-instruction schedule model.
module tb_mc_controller;

  logic       clk;
  logic       reset;
  logic [5:0] opeCode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  logic       mem_ready;
  logic       PCWrite, IRWrite, mem_req, MemWrite, RegWrite, ALUsrc, ALUsign, retire;
  logic [1:0] RegDst, WDsel, ALUop, ExtOp, PCsrc;
  logic [2:0] state;

  mc_controller dut (
    .clk(clk), .reset(reset), .opeCode(opeCode), .funct(funct), .zero(zero),
    .overflow(overflow), .mem_ready(mem_ready), .PCWrite(PCWrite), .IRWrite(IRWrite),
    .mem_req(mem_req), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .WDsel(WDsel), .ALUsrc(ALUsrc), .ALUop(ALUop), .ALUsign(ALUsign), .ExtOp(ExtOp),
    .PCsrc(PCsrc), .retire(retire), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic       irw;
    logic       mreq;
    logic       memw;
    logic       regw;
    logic [1:0] regdst;
    logic [1:0] wdsel;
    logic       alusrc;
    logic [1:0] aluop;
    logic       alusign;
    logic [1:0] extop;
    logic [1:0] pcsrc;
    logic       retire;
  } obs_t;

  // Instruction kinds: 0 addu 1 subu 2 slt 3 jr 4 ori 5 lw 6 sw 7 beq
  // 8 lui 9 j 10 jal 11 addi 12 addiu 13 undefined
  int k_op     [14] = '{0, 0, 0, 0, 13, 35, 43, 4, 15, 2, 3, 8, 9, 63};
  int k_fn     [14] = '{33, 35, 42, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int k_aluop  [14] = '{0, 1, 3, 0, 2, 0, 0, 1, 0, 0, 0, 0, 0, 0};
  int k_alusrc [14] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 1, 0};
  int k_alusign[14] = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0};
  int k_extop  [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 1, 1, 0};

  obs_t q_exp[$];
  logic q_mr[$];
  obs_t q_obs[$];
  obs_t r_obs;
  logic r_z, r_ov;
  int   n_checks;
  int   n_fail;

  // Expected per-cycle outputs of one instruction, built from its phase list
  task automatic build_sched(input int k, input int ifst, input int memst,
                             input logic z, input logic ov);
    obs_t e;
    bit   rtype, jump, mem_op;
    q_exp.delete();
    q_mr.delete();
    r_z   = z;
    r_ov  = ov;
    rtype = (k <= 2);
    jump  = (k == 3 || k == 9 || k == 10);
    mem_op = (k == 5 || k == 6);
    opeCode = 6'(k_op[k]);
    funct   = (k_op[k] == 0) ? 6'(k_fn[k]) : 6'($urandom_range(0, 63));
    for (int i = 0; i <= ifst; i++) begin
      e = '0;
      e.mreq = 1'b1;
      if (i == ifst) begin e.irw = 1'b1; e.pcw = 1'b1; end
      q_exp.push_back(e);
      q_mr.push_back(i == ifst);
    end
    e = '0;
    e.st = 3'd1;
    if (jump || k == 13) begin
      e.retire = 1'b1;
      if (jump) e.pcw = 1'b1;
      if (k == 3) e.pcsrc = 2'd3;
      if (k == 9 || k == 10) e.pcsrc = 2'd2;
      if (k == 10) begin e.regw = 1'b1; e.regdst = 2'd2; e.wdsel = 2'd2; end
      q_exp.push_back(e);
      q_mr.push_back(1'b0);
      return;
    end
    q_exp.push_back(e);
    q_mr.push_back(1'b0);
    e = '0;
    e.aluop   = 2'(k_aluop[k]);
    e.alusrc  = 1'(k_alusrc[k]);
    e.alusign = 1'(k_alusign[k]);
    e.extop   = 2'(k_extop[k]);
    e.st = 3'd2;
    if (k == 7) begin
      e.pcw = z;
      e.pcsrc = 2'd1;
      e.retire = 1'b1;
      q_exp.push_back(e);
      q_mr.push_back(1'b0);
      return;
    end
    q_exp.push_back(e);
    q_mr.push_back(1'b0);
    if (mem_op) begin
      for (int i = 0; i <= memst; i++) begin
        e.st = 3'd3;
        e.mreq = 1'b1;
        e.memw = (k == 6) && (i == memst);
        e.retire = e.memw;
        q_exp.push_back(e);
        q_mr.push_back(i == memst);
      end
      if (k == 6) return;
    end
    e.st = 3'd4;
    e.mreq = 1'b0;
    e.memw = 1'b0;
    e.retire = 1'b1;
    e.regw = !(k == 11 && ov);
    e.regdst = rtype ? 2'd1 : 2'd0;
    e.wdsel = (k == 5) ? 2'd1 : 2'd0;
    q_exp.push_back(e);
    q_mr.push_back(1'b0);
  endtask

  task automatic step(input logic mr, input logic rst);
    reset     = rst;
    mem_ready = mr;
    zero      = r_z;
    overflow  = r_ov;
    @(negedge clk);
    r_obs.st = state;       r_obs.pcw = PCWrite;    r_obs.irw = IRWrite;
    r_obs.mreq = mem_req;   r_obs.memw = MemWrite;  r_obs.regw = RegWrite;
    r_obs.regdst = RegDst;  r_obs.wdsel = WDsel;    r_obs.alusrc = ALUsrc;
    r_obs.aluop = ALUop;    r_obs.alusign = ALUsign; r_obs.extop = ExtOp;
    r_obs.pcsrc = PCsrc;    r_obs.retire = retire;
    @(posedge clk);
    #1;
  endtask

  task automatic exec_sched(input int n);
    q_obs.delete();
    for (int i = 0; i < n; i++) begin
      step(q_mr[i], 1'b0);
      q_obs.push_back(r_obs);
    end
  endtask

  task automatic test_reset;
    opeCode = 6'd43; funct = 6'd0; r_z = 1'b0; r_ov = 1'b0;
    step(1'b1, 1'b1);
    n_checks++;
    if ({r_obs.pcw, r_obs.irw, r_obs.mreq, r_obs.memw, r_obs.regw, r_obs.retire} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_enables got=%b exp=000000",
               {r_obs.pcw, r_obs.irw, r_obs.mreq, r_obs.memw, r_obs.regw, r_obs.retire});
    end
    step(1'b1, 1'b1);
    n_checks++;
    if (r_obs.st !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%0d exp=0", r_obs.st);
    end
  endtask

  task automatic test_addu;
    logic [2:0] seq [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    build_sched(0, 0, 0, 1'b0, 1'b0);
    exec_sched(q_exp.size());
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (q_obs[i].st !== seq[i] || q_obs[i].retire !== (i == 3) || q_obs[i].regw !== (i == 3)) begin
        n_fail++;
        $display("FAIL addu_cycle%0d got st=%0d ret=%b rw=%b exp st=%0d ret=%b rw=%b",
                 i, q_obs[i].st, q_obs[i].retire, q_obs[i].regw, seq[i], (i == 3), (i == 3));
      end
    end
    n_checks++;
    if (q_obs[3].regdst !== 2'b01) begin
      n_fail++;
      $display("FAIL addu_regdst got=%b exp=01", q_obs[3].regdst);
    end
  endtask

  task automatic test_lw_stall;
    build_sched(5, 0, 2, 1'b0, 1'b0);
    exec_sched(q_exp.size());
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (q_obs[i] !== q_exp[i]) begin
        n_fail++;
        $display("FAIL lw_stall_cycle%0d got=%h exp=%h", i, q_obs[i], q_exp[i]);
      end
    end
    n_checks++;
    if (q_obs[3].st !== 3'd3 || q_obs[5].st !== 3'd3 || q_obs[6].wdsel !== 2'b01 || q_obs[6].regw !== 1'b1) begin
      n_fail++;
      $display("FAIL lw_mem_wb got st3=%0d st5=%0d wdsel=%b rw=%b exp 3 3 01 1",
               q_obs[3].st, q_obs[5].st, q_obs[6].wdsel, q_obs[6].regw);
    end
  endtask

  task automatic test_beq;
    for (int zv = 1; zv >= 0; zv--) begin
      build_sched(7, 0, 0, 1'(zv), 1'b0);
      exec_sched(q_exp.size());
      n_checks++;
      if (q_obs[2].st !== 3'd2 || q_obs[2].pcw !== 1'(zv) || q_obs[2].pcsrc !== 2'b01 ||
          q_obs[2].retire !== 1'b1 || q_obs[2].aluop !== 2'b01) begin
        n_fail++;
        $display("FAIL beq_zero%0d got st=%0d pcw=%b pcsrc=%b ret=%b aluop=%b exp 2 %0d 01 1 01",
                 zv, q_obs[2].st, q_obs[2].pcw, q_obs[2].pcsrc, q_obs[2].retire, q_obs[2].aluop, zv);
      end
    end
  endtask

  task automatic test_jal;
    build_sched(10, 0, 0, 1'b0, 1'b0);
    exec_sched(q_exp.size());
    n_checks++;
    if (q_obs[1].pcw !== 1'b1 || q_obs[1].pcsrc !== 2'b10 || q_obs[1].regw !== 1'b1 ||
        q_obs[1].regdst !== 2'b10 || q_obs[1].wdsel !== 2'b10 || q_obs[1].retire !== 1'b1) begin
      n_fail++;
      $display("FAIL jal_id got=%h exp pcw=1 pcsrc=10 rw=1 regdst=10 wdsel=10 ret=1", q_obs[1]);
    end
    step(1'b0, 1'b0);
    n_checks++;
    if (r_obs.st !== 3'd0 || r_obs.irw !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_next got st=%0d irw=%b exp 0 0", r_obs.st, r_obs.irw);
    end
    // let the stalled fetch complete so the next test starts in IF
    opeCode = 6'd0;
  endtask

  task automatic test_addi;
    build_sched(11, 0, 0, 1'b0, 1'b1);
    exec_sched(q_exp.size());
    n_checks++;
    if (q_obs[3].st !== 3'd4 || q_obs[3].regw !== 1'b0 || q_obs[3].retire !== 1'b1) begin
      n_fail++;
      $display("FAIL addi_ovf got st=%0d rw=%b ret=%b exp 4 0 1", q_obs[3].st, q_obs[3].regw, q_obs[3].retire);
    end
    build_sched(11, 0, 0, 1'b0, 1'b0);
    exec_sched(q_exp.size());
    n_checks++;
    if (q_obs[3].regw !== 1'b1 || q_obs[3].alusign !== 1'b1 || q_obs[3].extop !== 2'b01 || q_obs[3].alusrc !== 1'b1) begin
      n_fail++;
      $display("FAIL addi_noovf got rw=%b sign=%b ext=%b src=%b exp 1 1 01 1",
               q_obs[3].regw, q_obs[3].alusign, q_obs[3].extop, q_obs[3].alusrc);
    end
  endtask

  task automatic test_reset_mid_sw;
    build_sched(6, 0, 0, 1'b0, 1'b0);
    exec_sched(3);
    step(1'b1, 1'b1);
    n_checks++;
    if (r_obs.st !== 3'd3 || r_obs.memw !== 1'b0 || r_obs.retire !== 1'b0 || r_obs.mreq !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_reset got st=%0d memw=%b ret=%b mreq=%b exp 3 0 0 0",
               r_obs.st, r_obs.memw, r_obs.retire, r_obs.mreq);
    end
    build_sched(13, 0, 0, 1'b0, 1'b0);
    opeCode = 6'b111111;
    exec_sched(q_exp.size());
    n_checks++;
    if (q_obs[0].st !== 3'd0) begin
      n_fail++;
      $display("FAIL post_reset_state got=%0d exp=0", q_obs[0].st);
    end
    n_checks++;
    if (q_obs[1].st !== 3'd1 || q_obs[1].pcw !== 1'b0 || q_obs[1].regw !== 1'b0 ||
        q_obs[1].memw !== 1'b0 || q_obs[1].retire !== 1'b1) begin
      n_fail++;
      $display("FAIL undef_id got=%h exp st=1 no writes ret=1", q_obs[1]);
    end
    step(1'b1, 1'b0);
    n_checks++;
    if (r_obs.st !== 3'd0) begin
      n_fail++;
      $display("FAIL undef_next got st=%0d exp 0", r_obs.st);
    end
    step(1'b0, 1'b0);
  endtask

  task automatic test_random;
    int k;
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 13);
      build_sched(k, $urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      exec_sched(q_exp.size());
      for (int i = 0; i < q_exp.size(); i++) begin
        n_checks++;
        if (q_obs[i] !== q_exp[i]) begin
          n_fail++;
          $display("FAIL random_k%0d_cycle%0d got=%h exp=%h", k, i, q_obs[i], q_exp[i]);
        end
      end
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    mem_ready = 1'b0;
    zero      = 1'b0;
    overflow  = 1'b0;
    opeCode   = 6'd0;
    funct     = 6'd0;
    r_z       = 1'b0;
    r_ov      = 1'b0;
    @(posedge clk);
    #1;
    test_reset;
    // test_reset leaves the FSM in IF; a fetch that sees a hit starts each test
    test_addu;
    test_lw_stall;
    test_beq;
    test_jal;
    test_addi;
    test_reset_mid_sw;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multi-cycle control FSM for the MIPS-lite datapath. It supports the same 13-instruction subset as the single-cycle decoder: addu, subu, slt, jr, ori, lw, sw, beq, lui, j, jal, addi, addiu. It sequences fetch, decode, execute, memory and writeback over several clocks so that the ALU and the unified memory port are shared across cycles. It stalls on a memory-ready handshake and emits a retire pulse per completed instruction.

Parameters:
RA_IDX, 5'd31, register index written by jal

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
opeCode  in  6  IR[31:26], held stable by datapath after IRWrite
funct  in  6  IR[5:0]
zero  in  1  ALU equality flag, valid in EXE
overflow  in  1  ALU signed-overflow flag, valid in EXE/WB
mem_ready  in  1  memory port completed the current access this cycle
PCWrite  out  1  PC register load enable
IRWrite  out  1  instruction register load enable
mem_req  out  1  memory access request (IF and MEM)
MemWrite  out  1  store strobe, qualified by mem_ready
RegWrite  out  1  register file write enable
RegDst  out  2  00 rt, 01 rd, 10 RA_IDX
WDsel  out  2  00 ALU result, 01 memory data, 10 PC+4
ALUsrc  out  1  0 rt data, 1 extended immediate
ALUop  out  2  00 add, 01 sub, 10 or, 11 slt
ALUsign  out  1  signed ALU op (addi, slt)
ExtOp  out  2  00 zero-ext, 01 sign-ext, 10 lui (imm<<16)
PCsrc  out  2  00 PC+4, 01 branch, 10 j/jal, 11 jr
retire  out  1  one-cycle pulse when an instruction completes
state  out  3  current FSM state, for debug

Behaviour:
- States (3-bit): IF=0, ID=1, EXE=2, MEM=3, WB=4. Reset: state=IF on the next edge.
- While reset=1, every enable (PCWrite, IRWrite, mem_req, MemWrite, RegWrite, retire) is forced to 0 combinationally. The same applies to a reset asserted mid-instruction: no partial write may occur.
- IF: mem_req=1.
  - mem_ready=0: stay in IF, no writes.
  - mem_ready=1: IRWrite=1, PCWrite=1 with PCsrc=00, go to ID.
- ID:
  - j: PCWrite=1, PCsrc=10.
  - jal: as j, plus RegWrite=1, RegDst=10, WDsel=10.
  - jr: PCWrite=1, PCsrc=11.
  - j, jal, jr: retire=1, next state IF.
  - Undecoded opcode/funct: retire=1, next state IF, no writes (treated as nop).
  - All other instructions: next state EXE.
- EXE: ALUop, ALUsrc, ALUsign and ExtOp are driven per instruction, with encodings identical to the single-cycle decoder.
  - beq: ALUop=01; PCWrite=zero, PCsrc=01; retire=1; next state IF.
  - lw, sw: ALUop=00, ALUsrc=1, ExtOp=01; next state MEM.
  - All other supported instructions: next state WB.
- MEM: mem_req=1; address/ALU controls are held at their EXE values.
  - mem_ready=0: stay in MEM.
  - sw with mem_ready=1: MemWrite=1, retire=1, next state IF.
  - lw with mem_ready=1: next state WB.
- WB: RegWrite=1, retire=1, next state IF.
  - lw: RegDst=00, WDsel=01.
  - addu, subu, slt: RegDst=01, WDsel=00.
  - ori, lui, addiu, addi: RegDst=00, WDsel=00.
  - addi with overflow=1: RegWrite=0, retire still 1.
- The EXE-phase ALU controls stay asserted through WB so the datapath result remains stable.
- Cycle counts, excluding stalls: j/jr/jal 2; beq 3; R-type and I-type ALU 4; sw 4; lw 5. Each mem_ready=0 cycle in IF or MEM adds one cycle.
- ALU controls, RegDst, WDsel, ExtOp and PCsrc are "don't care" outside the states listed above. They are driven to 0 there for determinism.
- state is a registered output. All other outputs are combinational from state, opeCode, funct, zero, overflow and mem_ready.

Decomposition:
- Shared package holds:
  - state encodings S_IF..S_WB;
  - opcode/funct constants for the 13 instructions;
  - ALUop, ExtOp, PCsrc, RegDst and WDsel encodings.
- Sub-module instr_decode (combinational) turns opeCode/funct into one-hot instruction flags plus an "unknown" flag.
- mc_controller holds the state register and the per-state output logic.

Test Plan:
- Reset, then addu (funct 100001), mem_ready=1: states 0→1→2→4→0; RegWrite=1 and RegDst=01 only in WB; retire pulses once, 4 cycles after leaving reset.
- lw with mem_ready low for 2 cycles in MEM: state holds 3 for 3 cycles total; WB has WDsel=01, RegWrite=1; 7 cycles total.
- beq: zero=1 gives PCWrite=1, PCsrc=01 in EXE; zero=0 gives PCWrite=0 in EXE; retire=1 in EXE in both cases.
- jal: in ID, PCWrite=1, PCsrc=10, RegWrite=1, RegDst=10, WDsel=10; next state IF after 2 cycles.
- addi with overflow=1 in WB: RegWrite=0, retire=1. Repeat with overflow=0: RegWrite=1, ALUsign=1, ExtOp=01.
- reset asserted while in MEM for sw with mem_ready=1: MemWrite=0 that cycle; state=IF next cycle; an undefined opcode 6'b111111 then goes IF→ID→IF with no writes.
